// File: rtl/img_corr_engine_if.sv
// Load/action bus between the pattern driver and img_corr_engine, plus the serial result pair.
interface img_corr_engine_if #(
    parameter int unsigned DATA_W = 8
) ();
    logic              in_valid;
    logic              in_valid2;
    logic [DATA_W-1:0] image;
    logic [DATA_W-1:0] template;
    logic [1:0]        image_size;
    logic [1:0]        action;
    logic              out_valid;
    logic              out_value;

    modport master (
        output in_valid, in_valid2, image, template, image_size, action,
        input  out_valid, out_value
    );

    modport slave (
        input  in_valid, in_valid2, image, template, image_size, action,
        output out_valid, out_value
    );
endinterface

// File: rtl/img_corr_engine.sv
// Zero-padded 3x3 cross-correlation over a stored square image with optional flip/negate,
// streaming each result MSB-first while the next pixel's 9-tap MAC runs alongside.
module img_corr_engine #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned MAX_LOG = 4,
    parameter int unsigned OUT_W   = 2 * DATA_W + 4
) (
    input logic              clk,
    input logic              rst_n,
    img_corr_engine_if.slave bus
);
    localparam int unsigned MAX_SIZE = 1 << MAX_LOG;
    localparam int unsigned CW       = MAX_LOG + 1;   // coordinate width, reaches MAX_SIZE
    localparam int unsigned AW       = 2 * MAX_LOG;
    localparam int unsigned LW       = $clog2(MAX_LOG + 1);
    localparam int unsigned BW       = $clog2(OUT_W);
    localparam logic [BW-1:0] LastBit = BW'(OUT_W - 1);

    typedef enum logic [2:0] {StIdle, StLoad, StReady, StCalc, StOut} state_e;

    state_e state_q, state_d;

    logic [DATA_W-1:0]   img_mem [MAX_SIZE*MAX_SIZE];
    logic [DATA_W-1:0]   tmpl_mem [9];
    logic [LW-1:0]       log_side_q, size_log;
    logic [CW-1:0]       side;
    logic [1:0]          action_q;
    logic [CW-1:0]       wr_r_q, wr_c_q;
    logic [3:0]          tcnt_q;
    logic [CW-1:0]       cr_q, cc_q;
    logic [3:0]          tap_q;
    logic [OUT_W-1:0]    acc_q, sh_q;
    logic [BW-1:0]       bit_q;
    logic                out_valid_q;

    logic                load_start, load_beat, calc_start, mac_en, res_load, out_done;
    logic                wr_ok, t_ok, in_range;
    logic [AW-1:0]       wr_addr, rd_addr;
    logic [3:0]          t_idx;
    logic [DATA_W-1:0]   pix_raw, pix_eff;
    logic [2*DATA_W-1:0] prod;
    int                  tap_i, tap_j, src_r, src_c, src_col;

    assign side = CW'(1) << log_side_q;

    // Side code to log2(side), clamped to the largest supported image.
    always_comb begin
        if (int'(bus.image_size) > int'(MAX_LOG) - 2) size_log = LW'(MAX_LOG);
        else size_log = LW'(int'(bus.image_size) + 2);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else state_q <= state_d;
    end

    // Next-state logic; an action request wins over a reload in READY.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.in_valid) state_d = StLoad;
            StLoad:  if (!bus.in_valid) state_d = StReady;
            StReady: begin
                if (bus.in_valid2) state_d = StCalc;
                else if (bus.in_valid) state_d = StLoad;
            end
            StCalc:  if (tap_q == 4'd9) state_d = StOut;
            StOut:   if (out_done) state_d = StReady;
            default: state_d = StIdle;
        endcase
    end

    assign load_start = (state_q != StLoad) && (state_d == StLoad);
    assign load_beat  = load_start || (state_q == StLoad && bus.in_valid);
    assign calc_start = (state_q == StReady) && (state_d == StCalc);
    assign mac_en     = (state_q == StCalc || state_q == StOut) && (tap_q < 4'd9);
    assign out_done   = (state_q == StOut) && (bit_q == LastBit) && (cr_q == side);
    assign res_load   = ((state_q == StCalc) && (tap_q == 4'd9)) ||
                        ((state_q == StOut) && (bit_q == LastBit) && (cr_q != side));

    assign wr_ok   = load_start || (wr_r_q < side);
    assign wr_addr = load_start ? '0 : {wr_r_q[MAX_LOG-1:0], wr_c_q[MAX_LOG-1:0]};
    assign t_ok    = load_start || (tcnt_q < 4'd9);
    assign t_idx   = load_start ? 4'd0 : tcnt_q;

    // Image/template storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (load_beat && wr_ok) img_mem[wr_addr] <= bus.image;
        if (load_beat && t_ok) tmpl_mem[t_idx] <= bus.template;
    end

    // Tap fetch with zero padding; the transform is applied on read only.
    always_comb begin
        tap_i    = int'(tap_q) / 3;
        tap_j    = int'(tap_q) % 3;
        src_r    = int'(cr_q) + tap_i - 1;
        src_c    = int'(cc_q) + tap_j - 1;
        in_range = (src_r >= 0) && (src_r < int'(side)) && (src_c >= 0) && (src_c < int'(side));
        src_col  = (action_q == 2'd1) ? int'(side) - 1 - src_c : src_c;
        rd_addr  = AW'(src_r * int'(MAX_SIZE) + src_col);
        pix_raw  = img_mem[rd_addr];
        pix_eff  = '0;
        if (in_range) pix_eff = (action_q == 2'd2) ? ~pix_raw : pix_raw;
        prod = tmpl_mem[(tap_q < 4'd9) ? tap_q : 4'd0] * pix_eff;
    end

    // Load pointers, MAC accumulator, pixel walk and serial shifter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            log_side_q  <= LW'(2);
            action_q    <= 2'd0;
            wr_r_q      <= '0;
            wr_c_q      <= '0;
            tcnt_q      <= '0;
            cr_q        <= '0;
            cc_q        <= '0;
            tap_q       <= '0;
            acc_q       <= '0;
            sh_q        <= '0;
            bit_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (load_start) begin
                log_side_q <= size_log;
                wr_r_q     <= '0;
                wr_c_q     <= CW'(1);
                tcnt_q     <= 4'd1;
            end else if (state_q == StLoad && bus.in_valid) begin
                if (wr_r_q < side) begin
                    if (wr_c_q == side - CW'(1)) begin
                        wr_c_q <= '0;
                        wr_r_q <= wr_r_q + CW'(1);
                    end else begin
                        wr_c_q <= wr_c_q + CW'(1);
                    end
                end
                if (tcnt_q < 4'd9) tcnt_q <= tcnt_q + 4'd1;
            end

            if (calc_start) begin
                action_q <= bus.action;
                cr_q     <= '0;
                cc_q     <= '0;
                tap_q    <= '0;
                acc_q    <= '0;
            end else if (mac_en) begin
                acc_q <= acc_q + OUT_W'(prod);
                tap_q <= tap_q + 4'd1;
            end

            if (res_load) begin
                sh_q        <= acc_q;
                out_valid_q <= 1'b1;
                bit_q       <= '0;
                acc_q       <= '0;
                tap_q       <= '0;
                if (cc_q == side - CW'(1)) begin
                    cc_q <= '0;
                    cr_q <= cr_q + CW'(1);
                end else begin
                    cc_q <= cc_q + CW'(1);
                end
            end else if (state_q == StOut) begin
                if (bit_q == LastBit) begin
                    out_valid_q <= 1'b0;
                    sh_q        <= '0;
                    bit_q       <= '0;
                end else begin
                    sh_q  <= {sh_q[OUT_W-2:0], 1'b0};
                    bit_q <= bit_q + BW'(1);
                end
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_value = out_valid_q & sh_q[OUT_W-1];

endmodule

// File: doc/img_corr_engine.md
# img_corr_engine

Parametrised successor to the image-action datapath. It stores one square image and a 3x3 template, then on each action request computes a zero-padded 3x3 cross-correlation over the whole image, with an optional pre-transform. Each result is streamed out serially, MSB-first, on a 1-bit output. It sits between the pattern-driven input bus and the serial result checker. It generalises pixel width and maximum image size, and adds horizontal-flip and negate modes.

## Interface
Parameters:
- DATA_W, 8, pixel and template bit width
- MAX_LOG, 4, log2 of the maximum image side (16)
- OUT_W, 2*DATA_W+4, serial result width; holds 9 full-scale products

Ports:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  image/template load strobe
- in_valid2  in  1  one-cycle action request
- image  in  DATA_W  pixel, raster order
- template  in  DATA_W  template coefficient, raster order
- image_size  in  2  side = 4<<code, sampled on the first in_valid cycle; codes above MAX_LOG-2 clamp to MAX_SIZE
- action  in  2  sampled with in_valid2: 0 = plain, 1 = horizontal flip, 2 = negate, 3 = plain
- out_valid  out  1  serial result window
- out_value  out  1  serial result bit

## Operation
- States: IDLE, LOAD, READY, CALC, OUT.
- IDLE→LOAD on in_valid. Capture image_size on the first beat.
- LOAD:
  - template is valid on the first 9 in_valid beats; ignore template after that.
  - image is valid on every beat, side*side beats in total.
  - in_valid falling edge →READY.
- READY: hold the image and template indefinitely.
  - in_valid2 → latch action →CALC.
  - in_valid → new LOAD, overwriting the previous image and template.
- CALC: sequential 9-tap MAC for pixel (0,0), then →OUT.
- OUT:
  - Shift the current OUT_W-bit result MSB-first.
  - Compute the next pixel in parallel (9 ≤ OUT_W cycles).
  - After side*side results →READY.
- Pre-transform, applied on read (the stored image is unchanged):
  - flip: p'(r,c) = p(r, side-1-c)
  - negate: p'(r,c) = 2^DATA_W-1-p(r,c)
- Result: R(r,c) = Σ T(i,j)·p'(r+i-1, c+j-1) for i,j in 0..2. Out-of-range pixels count as 0. Arithmetic is unsigned, full precision, no truncation.
- Output order is raster: row 0 col 0 first.
- Ignored inputs:
  - in_valid2 outside READY is ignored.
  - in_valid during CALC/OUT is ignored.
- Multiple action requests per loaded image are allowed and independent.

## Timing
- Reset: out_valid=0, out_value=0, state IDLE, action=0. Image and template contents are don't-care.
- Reset mid-operation aborts immediately. Both outputs are 0 asynchronously, and the FSM returns to IDLE.
- out_valid rises exactly 10 cycles after the in_valid2 cycle (9 MAC + 1 register).
- Once high, out_valid stays high for exactly side*side*OUT_W consecutive cycles with no gaps.
- out_value must be 0 whenever out_valid=0.
- Earliest next in_valid2: the cycle after out_valid falls.
- Back-to-back: a new LOAD may start the cycle after in_valid falls or after out_valid falls.
- A one-cycle in_valid2 pulse is required; holding it high longer is ignored after the first cycle.

## Test plan
- Load 4x4 image with p = 0..15 and template center = 1, others 0; action 0 → 16 results equal 0..15, each 20 bits, out_valid high for 320 cycles, rising 10 cycles after in_valid2.
- Same image, action 1 → result sequence 3,2,1,0,7,6,5,4,...,15,14,13,12.
- Same image, action 2 → results 255,254,...,240.
- 4x4 all-255 image, all-255 template, action 0 → corner results 260100, edge results 390150, the four interior results 585225; no overflow in 20 bits.
- 16x16 load with image_size=2, then image_size=3, both with a random template → both runs produce 256 results matching the reference model, i.e. the clamp is correct.
- Assert rst_n low for one cycle at the 50th output cycle → out_valid and out_value are 0 immediately. After reset, a new load with action 0 produces correct results. in_valid2 pulses issued during OUT have no effect.
